load_store_unit: RTL and testbench

Load/store unit between the single-cycle core's ALU and data memory. It takes the effective address, store data and funct3 of the current load/store. It drives a variable-latency word-wide memory through a request/acknowledge handshake, stalling the core until the access completes. It implements byte/halfword lanes for lb/lbu/lh/lhu/sb/sh/lw/sw, including alignment checks, load sign/zero extension and an access timeout.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Word-wide memory bus between the load/store unit (master) and data memory
// (slave), using a request/acknowledge handshake.
//   MemReq   master->slave  access request, held until ack or abort
//   MemWe    master->slave  request is a write
//   MemAdr   master->slave  word-aligned byte address
//   MemWData master->slave  lane-replicated store data
//   MemBe    master->slave  byte enables (0000 on reads)
//   MemAck   slave->master  write accepted / MemRData valid this cycle
//   MemRData slave->master  read word
// -----------------------------------------------------------------------------
interface load_store_unit_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAdr;
  logic [31:0] MemWData;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAdr, MemWData, MemBe,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAdr, MemWData, MemBe,
    output MemAck, MemRData
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sits between the core's ALU and a variable-latency word-wide data memory.
// Handles byte/halfword/word loads and stores with alignment checking, load
// sign/zero extension and an access timeout, stalling the core while the
// memory access is outstanding.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   MemRead_i    current instruction is a load
//   MemWrite_i   current instruction is a store
//   Funct3_i     access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   Adr_i        effective byte address
//   WriteData_i  store data (rs2)
//   ReadData_o   extended load result, valid in DONE (0 otherwise)
//   Stall_o      hold PC and register write this cycle
//   AccessErr_o  one-cycle error pulse (bad request or timeout)
//   mem          memory bus, master side
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255  // 1..65535 ACCESS cycles before abort
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        Funct3_i,
  input  logic [31:0]       Adr_i,
  input  logic [31:0]       WriteData_i,
  output logic [31:0]       ReadData_o,
  output logic              Stall_o,
  output logic              AccessErr_o,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam int unsigned    CntW    = 16;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;      // latched access type for read formatting
  logic [1:0]      off_q, off_d;    // latched byte offset within the word
  logic [31:0]     rdata_q, rdata_d;
  logic            to_q, to_d;      // last access ended by timeout

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic        req;
  logic        err;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  assign req = MemRead_i | MemWrite_i;

  // Stores have no unsigned variants, so Funct3[2]=1 is illegal for a write.
  assign err = (MemRead_i & MemWrite_i)
             | (Funct3_i inside {3'b011, 3'b110, 3'b111})
             | (MemWrite_i & Funct3_i[2])
             | ((Funct3_i[1:0] == 2'b01) & Adr_i[0])
             | ((Funct3_i[1:0] == 2'b10) & (Adr_i[1:0] != 2'b00));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    st_wdata = WriteData_i;
    st_be    = 4'b1111;
    case (Funct3_i[1:0])
      2'b00: begin
        st_wdata = {4{WriteData_i[7:0]}};
        st_be    = 4'b0001 << Adr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{WriteData_i[15:0]}};
        st_be    = 4'b0011 << {Adr_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load formatting: select the addressed lane and extend it.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    to_d    = to_q;

    case (state_q)
      IDLE: begin
        if (req && !err) begin
          state_d = ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          adr_d   = {Adr_i[31:2], 2'b00};
          wdata_d = MemWrite_i ? st_wdata : 32'h0;
          be_d    = MemWrite_i ? st_be : 4'b0000;
          f3_d    = Funct3_i;
          off_d   = Adr_i[1:0];
          to_d    = 1'b0;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + CntW'(1);
        // An ack arriving in the final allowed cycle still wins over timeout.
        if (mem.MemAck) begin
          rdata_d = we_q ? 32'h0 : fmt_load(f3_q, off_q, mem.MemRData);
          req_d   = 1'b0;
          to_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CntLast) begin
          rdata_d = 32'h0;
          req_d   = 1'b0;
          to_d    = 1'b1;
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem.MemReq   = req_q;
  assign mem.MemWe    = we_q;
  assign mem.MemAdr   = adr_q;
  assign mem.MemWData = wdata_q;
  assign mem.MemBe    = be_q;

  assign ReadData_o = (state_q == DONE) ? rdata_q : 32'h0;

  // Core-side strobes are suppressed while reset is asserted so a reset cycle
  // never stalls or flags the core.
  assign Stall_o     = !reset && (((state_q == IDLE) && req && !err) ||
                                  (state_q == ACCESS));
  assign AccessErr_o = !reset && (((state_q == IDLE) && req && err) ||
                                  ((state_q == DONE) && to_q));

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed self-checking bench for load_store_unit (TIMEOUT = 4). Inputs are
// driven 1 ns after each rising edge and outputs sampled 1 ns later, well
// away from the active edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessErr;

  int errors;
  int checks;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead_i   (MemRead),
    .MemWrite_i  (MemWrite),
    .Funct3_i    (Funct3),
    .Adr_i       (Adr),
    .WriteData_i (WriteData),
    .ReadData_o  (ReadData),
    .Stall_o     (Stall),
    .AccessErr_o (AccessErr),
    .mem         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Funct3    = 3'b000;
    Adr       = 32'h0;
    WriteData = 32'h0;
  endtask

  // One complete access issued in the current cycle: `waits` ACCESS cycles
  // without ack, then ack with `rdata`. Checks the registered bus in the ack
  // cycle and the result in DONE, then moves to the following IDLE cycle.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] adr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int waits, input logic [31:0] exp_adr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Adr = adr; WriteData = wd;
    #1;
    check({tag, ".c0_stall"}, 32'(Stall), 32'd1);
    check({tag, ".c0_err"}, 32'(AccessErr), 32'd0);
    step();
    for (int i = 0; i < waits; i++) begin
      check({tag, ".wait_req"}, 32'(bus.MemReq), 32'd1);
      check({tag, ".wait_stall"}, 32'(Stall), 32'd1);
      step();
    end
    bus.MemAck = 1'b1; bus.MemRData = rdata;
    #1;
    check({tag, ".req"}, 32'(bus.MemReq), 32'd1);
    check({tag, ".we"}, 32'(bus.MemWe), 32'(wr));
    check({tag, ".adr"}, bus.MemAdr, exp_adr);
    check({tag, ".be"}, 32'(bus.MemBe), 32'(exp_be));
    if (wr) check({tag, ".wdata"}, bus.MemWData, exp_wd);
    check({tag, ".acc_stall"}, 32'(Stall), 32'd1);
    step();
    bus.MemAck = 1'b0; bus.MemRData = 32'h0;
    idle_inputs();
    #1;
    check({tag, ".done_stall"}, 32'(Stall), 32'd0);
    check({tag, ".done_err"}, 32'(AccessErr), 32'd0);
    check({tag, ".done_req"}, 32'(bus.MemReq), 32'd0);
    check({tag, ".rdata"}, ReadData, exp_rd);
    step();
  endtask

  // A request that must be rejected in IDLE with no stall and no bus activity.
  task automatic do_error(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] adr);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Adr = adr; WriteData = 32'hA5A5_A5A5;
    #1;
    check({tag, ".err"}, 32'(AccessErr), 32'd1);
    check({tag, ".stall"}, 32'(Stall), 32'd0);
    check({tag, ".rdata"}, ReadData, 32'h0);
    step();
    idle_inputs();
    #1;
    check({tag, ".req"}, 32'(bus.MemReq), 32'd0);
    check({tag, ".err_gone"}, 32'(AccessErr), 32'd0);
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;
    idle_inputs();

    // ---- Reset: a pending load must not stall during the reset cycle ----
    reset = 1'b1;
    MemRead = 1'b1; Funct3 = 3'b010; Adr = 32'h64;
    step();
    check("rst.stall", 32'(Stall), 32'd0);
    check("rst.err", 32'(AccessErr), 32'd0);
    check("rst.req", 32'(bus.MemReq), 32'd0);
    check("rst.we", 32'(bus.MemWe), 32'd0);
    check("rst.be", 32'(bus.MemBe), 32'd0);
    check("rst.adr", bus.MemAdr, 32'h0);
    check("rst.wdata", bus.MemWData, 32'h0);
    check("rst.rdata", ReadData, 32'h0);
    reset = 1'b0;
    idle_inputs();
    step();

    // ---- lw with immediate ack ----
    do_access("lw64", 1, 0, 3'b010, 32'h64, 32'h0, 32'h0000_0019, 0,
              32'h64, 4'b0000, 32'h0, 32'h0000_0019);
    check("lw64.idle_rdata", ReadData, 32'h0);

    // ---- Lane loads from 0x80FF_7F01 ----
    do_access("lb103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 0,
              32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    do_access("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 0,
              32'h100, 4'b0000, 32'h0, 32'h0000_0080);
    do_access("lh102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_7F01, 0,
              32'h100, 4'b0000, 32'h0, 32'hFFFF_80FF);
    do_access("lhu102", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_7F01, 0,
              32'h100, 4'b0000, 32'h0, 32'h0000_80FF);
    do_access("lb100", 1, 0, 3'b000, 32'h100, 32'h0, 32'h80FF_7F01, 0,
              32'h100, 4'b0000, 32'h0, 32'h0000_0001);
    do_access("lh100", 1, 0, 3'b001, 32'h100, 32'h0, 32'h80FF_7F01, 0,
              32'h100, 4'b0000, 32'h0, 32'h0000_7F01);
    do_access("lb101", 1, 0, 3'b000, 32'h101, 32'h0, 32'h80FF_7F01, 0,
              32'h100, 4'b0000, 32'h0, 32'h0000_007F);

    // ---- lw with two wait cycles ----
    do_access("lw_wait", 1, 0, 3'b010, 32'h208, 32'h0, 32'hCAFE_F00D, 2,
              32'h208, 4'b0000, 32'h0, 32'hCAFE_F00D);

    // ---- Stores of 0x1234_5678 ----
    do_access("sb61", 0, 1, 3'b000, 32'h61, 32'h1234_5678, 32'h0, 0,
              32'h60, 4'b0010, 32'h7878_7878, 32'h0);
    do_access("sh62", 0, 1, 3'b001, 32'h62, 32'h1234_5678, 32'h0, 0,
              32'h60, 4'b1100, 32'h5678_5678, 32'h0);
    do_access("sh60", 0, 1, 3'b001, 32'h60, 32'h1234_5678, 32'h0, 0,
              32'h60, 4'b0011, 32'h5678_5678, 32'h0);
    do_access("sb63", 0, 1, 3'b000, 32'h63, 32'h1234_5678, 32'h0, 0,
              32'h60, 4'b1000, 32'h7878_7878, 32'h0);
    do_access("sw68", 0, 1, 3'b010, 32'h68, 32'h1234_5678, 32'h0, 1,
              32'h68, 4'b1111, 32'h1234_5678, 32'h0);

    // ---- Rejected requests ----
    do_error("err_lw66", 1, 0, 3'b010, 32'h66);
    do_error("err_sh61", 0, 1, 3'b001, 32'h61);
    do_error("err_f3_011", 1, 0, 3'b011, 32'h60);
    do_error("err_rw", 1, 1, 3'b010, 32'h60);
    do_error("err_sbu", 0, 1, 3'b100, 32'h60);
    do_error("err_f3_110", 1, 0, 3'b110, 32'h60);

    // ---- Timeout (TIMEOUT=4), preceded by a load leaving a nonzero latch ----
    do_access("pre_to", 1, 0, 3'b010, 32'h70, 32'h0, 32'h5555_AAAA, 0,
              32'h70, 4'b0000, 32'h0, 32'h5555_AAAA);
    MemRead = 1'b1; Funct3 = 3'b010; Adr = 32'h74;
    #1;
    check("to.c0_stall", 32'(Stall), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("to.req_high", 32'(bus.MemReq), 32'd1);
      check("to.stall_high", 32'(Stall), 32'd1);
      check("to.no_err_yet", 32'(AccessErr), 32'd0);
      step();
    end
    idle_inputs();
    #1;
    check("to.done_req", 32'(bus.MemReq), 32'd0);
    check("to.done_err", 32'(AccessErr), 32'd1);
    check("to.done_rdata", ReadData, 32'h0);
    check("to.done_stall", 32'(Stall), 32'd0);
    step();
    check("to.idle_err", 32'(AccessErr), 32'd0);
    check("to.idle_req", 32'(bus.MemReq), 32'd0);

    // ---- Reset during the 2nd ACCESS wait cycle ----
    MemRead = 1'b1; Funct3 = 3'b010; Adr = 32'h80;
    step();                       // 1st ACCESS wait cycle
    check("mr.req1", 32'(bus.MemReq), 32'd1);
    step();                       // 2nd ACCESS wait cycle
    check("mr.req2", 32'(bus.MemReq), 32'd1);
    reset = 1'b1;
    step();
    check("mr.req", 32'(bus.MemReq), 32'd0);
    check("mr.adr", bus.MemAdr, 32'h0);
    check("mr.be", 32'(bus.MemBe), 32'd0);
    check("mr.rdata", ReadData, 32'h0);
    check("mr.stall", 32'(Stall), 32'd0);
    check("mr.err", 32'(AccessErr), 32'd0);
    reset = 1'b0;
    idle_inputs();
    step();
    bus.MemAck = 1'b1; bus.MemRData = 32'hFFFF_FFFF;   // late ack, must be ignored
    #1;
    check("mr.late_stall", 32'(Stall), 32'd0);
    check("mr.late_err", 32'(AccessErr), 32'd0);
    step();
    bus.MemAck = 1'b0; bus.MemRData = 32'h0;
    #1;
    check("mr.late_req", 32'(bus.MemReq), 32'd0);
    check("mr.late_rdata", ReadData, 32'h0);
    step();
    do_access("mr.lw84", 1, 0, 3'b010, 32'h84, 32'h0, 32'hDEAD_BEEF, 0,
              32'h84, 4'b0000, 32'h0, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
